// File: rtl/sw_debounce_pkg.sv
// Shared defaults and helpers for the switch debouncer.
package sw_debounce_pkg;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefTickDiv = 100000;
  localparam int unsigned DefSamples = 4;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_tick.sv
// Sample-tick prescaler: one-cycle tick every TICK_DIV clocks, counting from 0 after reset.
module debounce_tick
  import sw_debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned    CntW   = cnt_width(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntMax);
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer with edge pulses and a single-entry change-event register.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned SAMPLES  = DefSamples
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ack,
  output logic             evt_overrun
);

  logic [WIDTH-1:0]   r_sync1, r_sync2;
  logic [SAMPLES-1:0] r_hist [WIDTH];
  logic [WIDTH-1:0]   r_stable, r_rise, r_fall;
  logic               r_evt_valid, r_evt_overrun;
  logic [WIDTH-1:0]   r_evt_data;

  logic               w_tick;
  logic [WIDTH-1:0]   w_set, w_clr;
  logic               w_chg, w_hs;

  debounce_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WIDTH); i++) r_hist[i] <= '0;
    end else if (w_tick) begin
      // Cast drops the oldest sample off the top of the shift.
      for (int i = 0; i < int'(WIDTH); i++) r_hist[i] <= SAMPLES'({r_hist[i], r_sync2[i]});
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_set[i] = (&r_hist[i]) & ~r_stable[i];
      w_clr[i] = ~(|r_hist[i]) & r_stable[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
    end else begin
      r_stable <= (r_stable | w_set) & ~w_clr;
      r_rise   <= w_set;
      r_fall   <= w_clr;
    end
  end

  assign w_chg = |(r_rise | r_fall);
  assign w_hs  = r_evt_valid & evt_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid   <= 1'b0;
      r_evt_data    <= '0;
      r_evt_overrun <= 1'b0;
    end else if (w_chg) begin
      // A coincident ack consumes the old event, so the new one is not an overrun.
      r_evt_valid   <= 1'b1;
      r_evt_data    <= r_stable;
      r_evt_overrun <= (r_evt_valid & ~evt_ack) | (r_evt_overrun & ~w_hs);
    end else if (w_hs) begin
      r_evt_valid   <= 1'b0;
      r_evt_overrun <= 1'b0;
    end
  end

  assign sw_stable   = r_stable;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign evt_valid   = r_evt_valid;
  assign evt_data    = r_evt_data;
  assign evt_overrun = r_evt_overrun;

endmodule
